// File: rtl/adc_frame_transmitter.sv
// Transmit-side framer: wraps a 16-bit ADC sample stream into START/TS/payload/END link frames
// and fills every other slot with comma words on the transceiver TX parallel interface.
module adc_frame_transmitter #(
  parameter int          FRAME_LEN  = 128,
  parameter logic [15:0] START_WORD = 16'hDEAD,
  parameter logic [15:0] END_WORD   = 16'hBEEF,
  parameter logic [15:0] IDLE_WORD  = 16'hBCBC,
  parameter logic [15:0] TS_INIT    = 16'h0000,
  parameter int          IDLE_GAP   = 0
) (
  input  logic        tx_std_clkout,
  input  logic        rst_n,
  input  logic        link_ready,
  input  logic        enable,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        ts_load,
  input  logic [15:0] ts_load_value,
  output logic [15:0] TX_data,
  output logic [1:0]  tx_datak,
  output logic        frame_active,
  output logic        frame_start,
  output logic [15:0] time_stamp,
  output logic [15:0] underflow_cnt
);

  // state_q names the word that the next rising edge puts on TX_data.
  // state   | meaning
  // IDLE    | send comma, wait for link_ready & enable
  // START   | send START_WORD
  // TS      | send current time stamp
  // PAYLOAD | send one sample (or repeat last on underflow), FRAME_LEN-3 slots
  // END     | send END_WORD, advance time stamp
  // GAP     | send IDLE_GAP forced commas between frames
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_TS, S_PAYLOAD, S_END, S_GAP
  } state_t;

  localparam logic [15:0] PAY_LAST = 16'(FRAME_LEN - 4);
  localparam logic [15:0] GAP_LAST = 16'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  datak_q, datak_d;
  logic        active_q, active_d;
  logic        start_q, start_d;
  logic [15:0] last_q, last_d;
  logic [15:0] under_q, under_d;
  logic [15:0] ts_q, ts_d;
  logic        go_frame;

  assign go_frame = link_ready & enable;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = IDLE_WORD;
    datak_d      = 2'b11;
    active_d     = 1'b0;
    start_d      = 1'b0;
    last_d       = last_q;
    under_d      = under_q;
    ts_d         = ts_q;
    sample_ready = 1'b0;

    if ((state_q inside {S_START, S_TS, S_PAYLOAD, S_END}) && !link_ready) begin
      // Link lost: drop the frame without END_WORD and without advancing the time stamp.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_frame) state_d = S_START;
        end
        S_START: begin
          data_d   = START_WORD;
          datak_d  = 2'b00;
          active_d = 1'b1;
          start_d  = 1'b1;
          state_d  = S_TS;
        end
        S_TS: begin
          data_d   = ts_q;
          datak_d  = 2'b00;
          active_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          sample_ready = 1'b1;
          datak_d      = 2'b00;
          active_d     = 1'b1;
          if (sample_valid) begin
            data_d = sample_data;
            last_d = sample_data;
          end else begin
            data_d  = last_q;
            under_d = (under_q == 16'hFFFF) ? under_q : under_q + 16'd1;
          end
          if (cnt_q == PAY_LAST) begin
            cnt_d   = '0;
            state_d = S_END;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_END: begin
          data_d   = END_WORD;
          datak_d  = 2'b00;
          active_d = 1'b1;
          ts_d     = ts_q + 16'd1;
          cnt_d    = '0;
          if (IDLE_GAP > 0) state_d = S_GAP;
          else              state_d = go_frame ? S_START : S_IDLE;
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = go_frame ? S_START : S_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (ts_load) ts_d = ts_load_value;
  end

  always_ff @(posedge tx_std_clkout) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= IDLE_WORD;
      datak_q  <= 2'b11;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      last_q   <= '0;
      under_q  <= '0;
      ts_q     <= TS_INIT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      datak_q  <= datak_d;
      active_q <= active_d;
      start_q  <= start_d;
      last_q   <= last_d;
      under_q  <= under_d;
      ts_q     <= ts_d;
    end
  end

  assign TX_data       = data_q;
  assign tx_datak      = datak_q;
  assign frame_active  = active_q;
  assign frame_start   = start_q;
  assign time_stamp    = ts_q;
  assign underflow_cnt = under_q;

endmodule

// File: tb/tb_adc_frame_transmitter.sv
// Directed bench for adc_frame_transmitter: framing, underflow, enable/link drop, time stamp.
module tb_adc_frame_transmitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_ready;
  logic        enable;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        ts_load;
  logic [15:0] ts_load_value;
  logic [15:0] TX_data;
  logic [1:0]  tx_datak;
  logic        frame_active;
  logic        frame_start;
  logic [15:0] time_stamp;
  logic [15:0] underflow_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] words [128];
  logic [1:0]  ks    [128];
  int          act_n;
  int          st_n;

  always #5 clk = ~clk;

  adc_frame_transmitter dut (
    .tx_std_clkout (clk),
    .rst_n         (rst_n),
    .link_ready    (link_ready),
    .enable        (enable),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .ts_load       (ts_load),
    .ts_load_value (ts_load_value),
    .TX_data       (TX_data),
    .tx_datak      (tx_datak),
    .frame_active  (frame_active),
    .frame_start   (frame_start),
    .time_stamp    (time_stamp),
    .underflow_cnt (underflow_cnt)
  );

  // The sample source advances only when the DUT accepts the current sample.
  task automatic tick();
    bit consumed;
    consumed = (sample_ready === 1'b1) && (sample_valid === 1'b1);
    @(posedge clk);
    #1;
    if (consumed) sample_data = sample_data + 16'd1;
  endtask

  // Waits (bounded) for frame_start, then records the 128 words of the frame.
  // Stimulus for the edge after word i is applied right after word i is recorded.
  task automatic capture(input int inv_lo, input int inv_hi, input int en_off_at,
                         input int ld_at, input logic [15:0] ld_val, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) return;
    act_n = 0;
    st_n  = 0;
    for (int i = 0; i < 128; i++) begin
      words[i] = TX_data;
      ks[i]    = tx_datak;
      if (frame_active === 1'b1) act_n++;
      if (frame_start === 1'b1) st_n++;
      sample_valid  = !((i + 1) >= inv_lo && (i + 1) <= inv_hi);
      ts_load       = (i == ld_at);
      ts_load_value = ld_val;
      if (i == en_off_at) enable = 1'b0;
      tick();
    end
    sample_valid = 1'b1;
    ts_load      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; link_ready = 1'b1; enable = 1'b0;
    sample_data = 16'h0001; sample_valid = 1'b1;
    ts_load = 1'b0; ts_load_value = 16'h0000;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (TX_data !== 16'hBCBC) begin errors++; $display("FAIL reset_data got=%h exp=bcbc", TX_data); end
    checks++; if (tx_datak !== 2'b11) begin errors++; $display("FAIL reset_datak got=%b exp=11", tx_datak); end
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL reset_sample_ready got=%b exp=0", sample_ready); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active got=%b exp=0", frame_active); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    checks++; if (time_stamp !== 16'h0000) begin errors++; $display("FAIL reset_ts got=%h exp=0000", time_stamp); end
    checks++; if (underflow_cnt !== 16'h0000) begin errors++; $display("FAIL reset_underflow got=%h exp=0000", underflow_cnt); end
  endtask

  task automatic test_frame();
    bit ok;
    logic [15:0] exp;
    rst_n = 1'b1; enable = 1'b1;
    capture(-1, -1, -1, -1, 16'h0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame1_start_timeout got=none exp=frame_start"); return; end
    for (int i = 0; i < 128; i++) begin
      exp = (i == 0) ? 16'hDEAD : (i == 1) ? 16'h0000 : (i == 127) ? 16'hBEEF : 16'(i - 1);
      checks++;
      if (words[i] !== exp || ks[i] !== 2'b00) begin
        errors++; $display("FAIL frame1_word%0d got=%h/%b exp=%h/00", i, words[i], ks[i], exp);
      end
    end
    checks++; if (st_n !== 1) begin errors++; $display("FAIL frame1_start_pulses got=%0d exp=1", st_n); end
    checks++; if (act_n !== 128) begin errors++; $display("FAIL frame1_active_cycles got=%0d exp=128", act_n); end
    checks++; if (time_stamp !== 16'h0001) begin errors++; $display("FAIL frame1_ts_incr got=%h exp=0001", time_stamp); end
    checks++; if (TX_data !== 16'hDEAD || frame_start !== 1'b1) begin
      errors++; $display("FAIL back_to_back got=%h/%b exp=dead/1", TX_data, frame_start);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    logic [15:0] exp;
    capture(-1, -1, 52, -1, 16'h0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame2_start_timeout got=none exp=frame_start"); return; end
    for (int i = 0; i < 128; i++) begin
      exp = (i == 0) ? 16'hDEAD : (i == 1) ? 16'h0001 : (i == 127) ? 16'hBEEF : 16'(i + 124);
      checks++;
      if (words[i] !== exp || ks[i] !== 2'b00) begin
        errors++; $display("FAIL frame2_word%0d got=%h/%b exp=%h/00", i, words[i], ks[i], exp);
      end
    end
    checks++; if (act_n !== 128) begin errors++; $display("FAIL frame2_active_cycles got=%0d exp=128", act_n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (TX_data !== 16'hBCBC || tx_datak !== 2'b11 || frame_active !== 1'b0) begin
        errors++; $display("FAIL idle_after_disable%0d got=%h/%b/%b exp=bcbc/11/0", i, TX_data, tx_datak, frame_active);
      end
      tick();
    end
  endtask

  task automatic test_underflow();
    bit ok;
    logic [15:0] exp;
    sample_data = 16'h0001;
    enable = 1'b1;
    capture(12, 14, 100, -1, 16'h0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL underflow_start_timeout got=none exp=frame_start"); return; end
    for (int i = 0; i < 128; i++) begin
      if (i == 0)        exp = 16'hDEAD;
      else if (i == 1)   exp = 16'h0002;
      else if (i == 127) exp = 16'hBEEF;
      else if (i <= 11)  exp = 16'(i - 1);
      else if (i <= 14)  exp = 16'h000A;
      else               exp = 16'(i - 4);
      checks++;
      if (words[i] !== exp || ks[i] !== 2'b00) begin
        errors++; $display("FAIL underflow_word%0d got=%h/%b exp=%h/00", i, words[i], ks[i], exp);
      end
    end
    checks++; if (underflow_cnt !== 16'd3) begin errors++; $display("FAIL underflow_cnt got=%0d exp=3", underflow_cnt); end
    checks++; if (act_n !== 128) begin errors++; $display("FAIL underflow_active_cycles got=%0d exp=128", act_n); end
  endtask

  task automatic test_link_drop();
    bit ok;
    ok = 1'b0;
    enable = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (frame_start === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL linkdrop_start_timeout got=none exp=frame_start"); return; end
    for (int i = 0; i < 52; i++) tick();
    link_ready = 1'b0;
    tick();
    checks++; if (TX_data !== 16'hBCBC || tx_datak !== 2'b11) begin
      errors++; $display("FAIL linkdrop_word got=%h/%b exp=bcbc/11", TX_data, tx_datak);
    end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL linkdrop_active got=%b exp=0", frame_active); end
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL linkdrop_sample_ready got=%b exp=0", sample_ready); end
    checks++; if (time_stamp !== 16'h0003) begin errors++; $display("FAIL linkdrop_ts got=%h exp=0003", time_stamp); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (TX_data !== 16'hBCBC || frame_active !== 1'b0) begin
      errors++; $display("FAIL linkdrop_stays_idle got=%h/%b exp=bcbc/0", TX_data, frame_active);
    end
    link_ready = 1'b1;
    capture(-1, -1, 1, -1, 16'h0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL relink_start_timeout got=none exp=frame_start"); return; end
    checks++; if (words[0] !== 16'hDEAD) begin errors++; $display("FAIL relink_start got=%h exp=dead", words[0]); end
    checks++; if (words[1] !== 16'h0003) begin errors++; $display("FAIL relink_ts got=%h exp=0003", words[1]); end
    checks++; if (words[127] !== 16'hBEEF) begin errors++; $display("FAIL relink_end got=%h exp=beef", words[127]); end
    checks++; if (act_n !== 128) begin errors++; $display("FAIL relink_active_cycles got=%0d exp=128", act_n); end
  endtask

  task automatic test_ts_load();
    bit ok;
    ts_load = 1'b1; ts_load_value = 16'hFFFF;
    tick();
    ts_load = 1'b0;
    checks++; if (time_stamp !== 16'hFFFF) begin errors++; $display("FAIL ts_load_ffff got=%h exp=ffff", time_stamp); end
    enable = 1'b1;
    capture(-1, -1, -1, -1, 16'h0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tsA_start_timeout got=none exp=frame_start"); return; end
    checks++; if (words[1] !== 16'hFFFF) begin errors++; $display("FAIL tsA_word got=%h exp=ffff", words[1]); end
    checks++; if (words[127] !== 16'hBEEF) begin errors++; $display("FAIL tsA_end got=%h exp=beef", words[127]); end
    checks++; if (time_stamp !== 16'h0000) begin errors++; $display("FAIL ts_wrap got=%h exp=0000", time_stamp); end
    capture(-1, -1, -1, 126, 16'h1234, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tsB_start_timeout got=none exp=frame_start"); return; end
    checks++; if (words[1] !== 16'h0000) begin errors++; $display("FAIL tsB_word got=%h exp=0000", words[1]); end
    checks++; if (time_stamp !== 16'h1234) begin errors++; $display("FAIL ts_load_wins got=%h exp=1234", time_stamp); end
    tick();
    checks++; if (TX_data !== 16'h1234 || tx_datak !== 2'b00) begin
      errors++; $display("FAIL tsC_word got=%h/%b exp=1234/00", TX_data, tx_datak);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 20; i++) tick();
    checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL midframe_active got=%b exp=1", frame_active); end
    rst_n = 1'b0;
    tick();
    checks++; if (TX_data !== 16'hBCBC || tx_datak !== 2'b11) begin
      errors++; $display("FAIL midreset_word got=%h/%b exp=bcbc/11", TX_data, tx_datak);
    end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL midreset_active got=%b exp=0", frame_active); end
    checks++; if (time_stamp !== 16'h0000) begin errors++; $display("FAIL midreset_ts got=%h exp=0000", time_stamp); end
    checks++; if (underflow_cnt !== 16'h0000) begin errors++; $display("FAIL midreset_underflow got=%h exp=0000", underflow_cnt); end
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL midreset_sample_ready got=%b exp=0", sample_ready); end
    enable = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (TX_data !== 16'hBCBC || frame_active !== 1'b0) begin
      errors++; $display("FAIL postreset_idle got=%h/%b exp=bcbc/0", TX_data, frame_active);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_enable_drop();
    test_underflow();
    test_link_drop();
    for (int i = 0; i < 130; i++) tick();
    test_ts_load();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
